sensor_frame_packer: RTL

Sits directly downstream of the sensor acquisition stage. Consumes its 16-bit AXI-Stream frames (header, timestamp, 1024 pixels, footer), validates the framing, and packs word pairs into 32-bit beats for the DMA. Frames are buffered store-and-forward: only complete, well-formed frames reach the master port, and malformed or overflowing frames are discarded whole.

---
 rtl/sensor_frame_pkg.sv | 27 ++
 rtl/frame_buffer_ram.sv | 30 +++
 rtl/sensor_frame_packer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_pkg.sv
`timescale 1ns/1ps
// Shared framing constants, input FSM encoding and buffer beat layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_frame_pkg;

    localparam logic [15:0] HEADER_VALUE = 16'hAAAA;
    localparam logic [15:0] FOOTER_VALUE = 16'h5555;
    localparam int          DATA_WORDS   = 1024;
    // header+timestamp beat, DATA_WORDS/2 pixel beats, lone footer beat
    localparam int          FRAME_BEATS  = 514;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_TSTAMP = 4'd1,
        ST_DATA   = 4'd2,
        ST_FOOTER = 4'd3,
        ST_DROP   = 4'd4
    } state_t;

    // One frame-buffer entry: packed word pair plus end-of-frame flag.
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

endpackage

// File: rtl/frame_buffer_ram.sv
`timescale 1ns/1ps
// Simple dual-port frame buffer: one write port, one registered read port.
// Latency: read data valid the cycle after rd_en.
// Backpressure: none; callers guarantee pointer discipline.
module frame_buffer_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 33
) (
    input  logic                  master_clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // write port
    always_ff @(posedge master_clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // registered read port
    always_ff @(posedge master_clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sensor_frame_packer.sv
`timescale 1ns/1ps
// Validates 16-bit sensor frames and packs word pairs into 32-bit beats, store-and-forward.
// Latency: first beat valid within 3 cycles after the footer; 1 beat/cycle sustained.
// Backpressure: input never stalls (bad/overflowing frames dropped whole); output holds under tready=0.
module sensor_frame_packer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WORDS = sensor_frame_pkg::DATA_WORDS
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic [3:0]  dbg_state
);
    import sensor_frame_pkg::*;

    // DATA_WORDS is assumed even so the footer always lands on an even index.
    localparam int CNT_W = $clog2(DATA_WORDS);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   wptr, cwptr, rptr;
    logic [15:0]           hold;
    logic                  ovf, full;
    logic [CNT_W-1:0]      pix_cnt;
    logic                  wr_req, wr_en, commit, err, hold_load;
    logic                  is_header, is_footer;
    beat_t                 wr_beat, rd_beat, skid_beat;
    logic                  rd_pend, skid_vld, pop, rd_issue;
    logic [1:0]            occ_nxt;

    assign s_axis_tready = 1'b1;
    assign dbg_state     = state;
    assign is_header     = (s_axis_tdata == HEADER_VALUE);
    assign is_footer     = (s_axis_tdata == FOOTER_VALUE);
    // extra pointer bit distinguishes full (MSB differs) from empty
    assign full          = ((wptr ^ rptr) == {1'b1, {ADDR_WIDTH{1'b0}}});
    assign wr_en         = wr_req && !full && !ovf;

    // input FSM state register
    always_ff @(posedge master_clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // input FSM next-state decode
    always_comb begin
        state_nxt = state;
        if (s_axis_tvalid) begin
            case (state)
                ST_IDLE: begin
                    if (is_header && !s_axis_tlast) state_nxt = ST_TSTAMP;
                    else if (!s_axis_tlast)         state_nxt = ST_DROP;
                end
                ST_TSTAMP: state_nxt = s_axis_tlast ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                    if (s_axis_tlast)                              state_nxt = ST_IDLE;
                    else if (pix_cnt == CNT_W'(DATA_WORDS - 1))    state_nxt = ST_FOOTER;
                end
                ST_FOOTER: state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
                ST_DROP:   if (s_axis_tlast) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // input FSM actions: hold even words, write pairs, commit or flag errors
    always_comb begin
        wr_req    = 1'b0;
        wr_beat   = '0;
        hold_load = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        if (s_axis_tvalid) begin
            case (state)
                ST_IDLE: begin
                    if (is_header && !s_axis_tlast) hold_load = 1'b1;
                    else                            err       = 1'b1;
                end
                ST_TSTAMP, ST_DATA: begin
                    if (s_axis_tlast) begin
                        err = 1'b1;
                    end else if (state == ST_DATA && !pix_cnt[0]) begin
                        hold_load = 1'b1;
                    end else begin
                        wr_req  = 1'b1;
                        wr_beat = '{last: 1'b0, data: {s_axis_tdata, hold}};
                    end
                end
                ST_FOOTER: begin
                    // an earlier lost beat, or no room for the footer, kills the frame here
                    if (is_footer && s_axis_tlast && !ovf && !full) begin
                        wr_req  = 1'b1;
                        wr_beat = '{last: 1'b1, data: {16'h0000, s_axis_tdata}};
                        commit  = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // write-side pointers, pixel counter, overflow flag and frame counters
    always_ff @(posedge master_clock) begin
        if (reset) begin
            wptr        <= '0;
            cwptr       <= '0;
            hold        <= '0;
            ovf         <= 1'b0;
            pix_cnt     <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (hold_load) hold <= s_axis_tdata;
            if (state == ST_TSTAMP)                    pix_cnt <= '0;
            else if (state == ST_DATA && s_axis_tvalid) pix_cnt <= pix_cnt + 1'b1;
            if (state == ST_IDLE)      ovf <= 1'b0;
            else if (wr_req && full)   ovf <= 1'b1;
            if (err)        wptr <= cwptr;
            else if (wr_en) wptr <= wptr + 1'b1;
            if (commit) begin
                cwptr       <= wptr + 1'b1;
                frame_count <= frame_count + 1'b1;
            end
            if (err) drop_count <= drop_count + 1'b1;
        end
    end

    frame_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      ($bits(beat_t))
    ) u_ram (
        .master_clock (master_clock),
        .wr_en        (wr_en),
        .wr_addr      (wptr[ADDR_WIDTH-1:0]),
        .wr_data      (wr_beat),
        .rd_en        (rd_issue),
        .rd_addr      (rptr[ADDR_WIDTH-1:0]),
        .rd_data      (rd_beat)
    );

    // Output register + skid hold at most two beats; a read is only launched
    // when its data is certain to find a free slot on arrival.
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign occ_nxt  = {1'b0, m_axis_tvalid} + {1'b0, skid_vld} + {1'b0, rd_pend} - {1'b0, pop};
    assign rd_issue = (rptr != cwptr) && (occ_nxt < 2'd2);

    // read pointer, RAM return tracking and output/skid registers
    always_ff @(posedge master_clock) begin
        if (reset) begin
            rptr          <= '0;
            rd_pend       <= 1'b0;
            skid_vld      <= 1'b0;
            skid_beat     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) rptr <= rptr + 1'b1;
            if (!m_axis_tvalid || m_axis_tready) begin
                if (skid_vld) begin
                    {m_axis_tlast, m_axis_tdata} <= skid_beat;
                    m_axis_tvalid                <= 1'b1;
                    skid_vld                     <= rd_pend;
                    skid_beat                    <= rd_beat;
                end else if (rd_pend) begin
                    {m_axis_tlast, m_axis_tdata} <= rd_beat;
                    m_axis_tvalid                <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_vld  <= 1'b1;
                skid_beat <= rd_beat;
            end
        end
    end

endmodule
